// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared constants and types for the instruction prefetch buffer.
//   INST_W / ADDR_W : instruction and address widths
//   NOP_INST        : canonical RV32 NOP (addi x0,x0,0)
//   PC_INC          : sequential fetch stride
//   fetch_entry_t   : one queue entry {pc, inst}
//   pc_next()       : PC + 4 with natural 32-bit wrap
package inst_prefetch_buffer_pkg;
   localparam int INST_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
   localparam logic [ADDR_W-1:0] PC_INC   = 32'd4;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
      return pc + PC_INC;
   endfunction
endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// Bus bundle between the prefetcher, the instruction memory port and the IF stage.
//   mem_*  : fetch request (req/gnt handshake) and in-order response (rvalid/rdata)
//   if_*   : head-of-queue presentation to IF under valid/ready
// modport master : prefetcher side
// modport slave  : memory + IF-stage side
interface inst_prefetch_buffer_if;
   import inst_prefetch_buffer_pkg::*;

   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [INST_W-1:0] mem_rdata_i;
   logic              if_valid_o;
   logic              if_ready_i;
   logic [ADDR_W-1:0] if_pc_o;
   logic [ADDR_W-1:0] if_pcPlusFour_o;
   logic [INST_W-1:0] if_inst_o;

   modport master (
      output mem_req_o, mem_addr_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output if_valid_o, if_pc_o, if_pcPlusFour_o, if_inst_o,
      input  if_ready_i
   );

   modport slave (
      input  mem_req_o, mem_addr_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  if_valid_o, if_pc_o, if_pcPlusFour_o, if_inst_o,
      output if_ready_i
   );
endinterface

// File: rtl/inst_prefetch_buffer_pf_fifo.sv
// pf_fifo: DEPTH-entry circular queue of {pc, inst}.
//   clk, reset     : clock, async active-high reset
//   clear          : drop all entries (takes priority over push/pop)
//   push/push_data : enqueue at tail
//   pop            : dequeue head (ignored when empty)
//   head/valid     : head entry and non-empty flag
//   count          : occupancy
// When empty, head holds the last entry that was presented so the outputs
// do not toggle on stale storage; after reset it reads as zero.
module pf_fifo
   import inst_prefetch_buffer_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic             valid,
   output logic [CNT_W-1:0] count
);
   fetch_entry_t     mem [DEPTH];
   fetch_entry_t     hold_q;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign valid   = (count != '0);
   assign do_push = push & ~clear;
   assign do_pop  = pop & valid & ~clear;
   assign head    = valid ? mem[rd_ptr] : hold_q;

   // storage needs no reset: a slot is only read after it has been written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         hold_q <= '0;
      end else begin
         if (valid) hold_q <= mem[rd_ptr];
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         end
      end
   end
endmodule

// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: sequential instruction prefetcher feeding IF/ID.
//   clk, reset     : clock, async active-high reset
//   redirect_i     : taken branch / jump; flushes queue and stale responses
//   redirect_pc_i  : new target, low two bits forced to zero
//   bus (master)   : memory request/response port and IF-stage head output
// Requests are credit-limited so queued + in-flight words never exceed DEPTH,
// which guarantees every accepted response has a free slot.
module inst_prefetch_buffer
   import inst_prefetch_buffer_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  redirect_i,
   input  logic [ADDR_W-1:0]     redirect_pc_i,
   inst_prefetch_buffer_if.master bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc, resp_pc, target, pc4_hold;
   logic [CNT_W-1:0]  inflight, discard, count;
   logic              grant, rv, push, pop, fifo_valid;
   fetch_entry_t      push_data, head;

   assign target = redirect_pc_i & ~ADDR_W'(3);

   assign bus.mem_req_o  = ~reset & ~redirect_i &
                           (({1'b0, count} + {1'b0, inflight}) < (CNT_W+1)'(DEPTH));
   assign bus.mem_addr_o = fetch_pc;

   assign grant = bus.mem_req_o & bus.mem_gnt_i;
   // a response with nothing outstanding is a protocol error and is ignored
   assign rv    = bus.mem_rvalid_i & (inflight != '0);
   assign push  = rv & ~redirect_i & (discard == '0);
   assign pop   = fifo_valid & bus.if_ready_i & ~redirect_i;

   assign push_data = '{pc: resp_pc, inst: bus.mem_rdata_i};

   pf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (redirect_i),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .valid     (fifo_valid),
      .count     (count)
   );

   assign bus.if_valid_o      = fifo_valid;
   assign bus.if_pc_o         = head.pc;
   assign bus.if_inst_o       = head.inst;
   assign bus.if_pcPlusFour_o = fifo_valid ? pc_next(head.pc) : pc4_hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
         pc4_hold <= '0;
      end else begin
         inflight <= inflight + CNT_W'(grant) - CNT_W'(rv);
         if (fifo_valid) pc4_hold <= pc_next(head.pc);
         if (redirect_i) begin
            fetch_pc <= target;
            resp_pc  <= target;
            // every outstanding response predates the redirect; words already
            // marked for discard are a subset of inflight, so this also
            // covers back-to-back redirects without double counting
            discard  <= inflight - CNT_W'(rv);
         end else begin
            if (grant) fetch_pc <= pc_next(fetch_pc);
            if (push)  resp_pc  <= pc_next(resp_pc);
            if (rv && discard != '0) discard <= discard - CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
module tb_inst_prefetch_buffer;
   import inst_prefetch_buffer_pkg::*;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        rsp_en = 1'b1;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   inst_prefetch_buffer_if b1 ();
   inst_prefetch_buffer_if b2 ();

   inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
      .clk(clk), .reset(reset), .redirect_i(redirect), .redirect_pc_i(redirect_pc), .bus(b1));

   inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .clk(clk), .reset(reset), .redirect_i(1'b0), .redirect_pc_i(32'h0), .bus(b2));

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // ---------------- memory responder for b1: in-order, one word per cycle
   logic [31:0] mq[$];
   always @(negedge clk) begin
      if (reset) mq.delete();
      else begin
         if (b1.mem_rvalid_i && mq.size() != 0) mq.delete(0);
         if (b1.mem_req_o && b1.mem_gnt_i) mq.push_back(b1.mem_addr_o);
      end
   end
   always @(posedge clk) begin
      #2;
      b1.mem_rvalid_i = !reset && rsp_en && mq.size() != 0;
      b1.mem_rdata_i  = (mq.size() != 0) ? inst_of(mq[0]) : 32'h0;
   end

   // ---------------- responder for b2: always granted, fixed 1-cycle latency
   logic        g2;
   logic [31:0] a2;
   always @(negedge clk) begin
      g2 = !reset && b2.mem_req_o && b2.mem_gnt_i;
      a2 = b2.mem_addr_o;
   end
   always @(posedge clk) begin
      #2;
      b2.mem_rvalid_i = g2 && !reset;
      b2.mem_rdata_i  = ~a2;
   end

   logic [31:0] pcs2[3], pc4s2[3], insts2[3];
   int n2 = 0;
   always @(negedge clk) begin
      if (reset) n2 = 0;
      else if (b2.if_valid_o && n2 < 3) begin
         pcs2[n2] = b2.if_pc_o; pc4s2[n2] = b2.if_pcPlusFour_o; insts2[n2] = b2.if_inst_o;
         n2++;
      end
   end

   // ---------------- behavioural model for b1: request list tagged with a
   // redirect epoch; a response is kept only if its request is of the current
   // epoch and no redirect is happening right now
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
   typedef struct { logic [31:0] pc; int ep; } req_t;
   ent_t        eq[$];
   req_t        pend[$];
   req_t        r;
   int          epoch = 0;
   logic [31:0] mpc = 32'h0;
   logic        exp_req, vis, grant_m;

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_req",   32'(b1.mem_req_o),  32'h0);
         chk("rst_valid", 32'(b1.if_valid_o), 32'h0);
         chk("rst_pc",    b1.if_pc_o,         32'h0);
         chk("rst_pc4",   b1.if_pcPlusFour_o, 32'h0);
         chk("rst_inst",  b1.if_inst_o,       32'h0);
         eq.delete(); pend.delete(); mpc = 32'h0;
      end else begin
         exp_req = !redirect && (eq.size() + pend.size() < DEPTH);
         chk("mem_req", 32'(b1.mem_req_o), 32'(exp_req));
         if (exp_req) chk("mem_addr", b1.mem_addr_o, mpc);
         vis = (eq.size() != 0);
         chk("if_valid", 32'(b1.if_valid_o), 32'(vis));
         if (vis) begin
            chk("if_pc",   b1.if_pc_o,         eq[0].pc);
            chk("if_pc4",  b1.if_pcPlusFour_o, eq[0].pc + 32'd4);
            chk("if_inst", b1.if_inst_o,       eq[0].inst);
         end
         assert (!(b1.mem_rvalid_i && pend.size() == 0))
            else $error("protocol: rvalid with nothing outstanding");
         grant_m = exp_req && b1.mem_gnt_i;
         if (redirect) begin
            if (b1.mem_rvalid_i && pend.size() != 0) pend.delete(0);
            eq.delete();
            epoch++;
            mpc = {redirect_pc[31:2], 2'b00};
         end else begin
            if (vis && b1.if_ready_i) eq.delete(0);
            if (b1.mem_rvalid_i && pend.size() != 0) begin
               r = pend[0];
               pend.delete(0);
               if (r.ep == epoch) eq.push_back('{r.pc, inst_of(r.pc)});
            end
            if (grant_m) begin
               pend.push_back('{mpc, epoch});
               mpc = mpc + 32'd4;
            end
         end
      end
   end

   task automatic wait_valid(input string nm, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (b1.if_valid_o) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL %s timeout waiting for if_valid_o", nm);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   logic [31:0] pcs1[8], pc4s1[8];
   int          first, grants;
   logic        ok;

   initial begin
      b1.mem_gnt_i = 1'b1; b1.if_ready_i = 1'b1;
      b2.mem_gnt_i = 1'b1; b2.if_ready_i = 1'b1;
      b1.mem_rvalid_i = 1'b0; b1.mem_rdata_i = 32'h0;
      b2.mem_rvalid_i = 1'b0; b2.mem_rdata_i = 32'h0;
      #1 reset = 1'b1;
      tick(); tick();

      // 1: streaming after reset
      reset = 1'b0;
      first = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (b1.if_valid_o && first < 0) first = k;
         pcs1[k] = b1.if_pc_o; pc4s1[k] = b1.if_pcPlusFour_o;
         tick();
      end
      chk("t1_first_valid_cycle", 32'(first), 32'd2);
      chk("t1_pc0", pcs1[2], 32'h0);
      chk("t1_pc1", pcs1[3], 32'h4);
      chk("t1_pc2", pcs1[4], 32'h8);
      chk("t1_pc4", pc4s1[3], 32'h8);

      // 5: wrap-around instance
      chk("t5_n",     32'(n2),   32'd3);
      chk("t5_pc0",   pcs2[0],   32'hFFFF_FFF8);
      chk("t5_pc1",   pcs2[1],   32'hFFFF_FFFC);
      chk("t5_pc2",   pcs2[2],   32'h0000_0000);
      chk("t5_pc4_1", pc4s2[1],  32'h0000_0000);
      chk("t5_inst0", insts2[0], 32'h0000_0007);

      // 3: redirect with two responses outstanding, unaligned target
      rsp_en = 1'b0;
      tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0; rsp_en = 1'b1;
      @(negedge clk);
      chk("t3_req",  32'(b1.mem_req_o), 32'd1);
      chk("t3_addr", b1.mem_addr_o,     32'h0000_0100);
      wait_valid("t3_wait", ok);
      if (ok) begin
         chk("t3_pc",   b1.if_pc_o,   32'h0000_0100);
         chk("t3_inst", b1.if_inst_o, inst_of(32'h0000_0100));
      end
      repeat (4) tick();

      // 4: redirect coinciding with a response and a pop
      redirect = 1'b1; redirect_pc = 32'h0000_0400;
      @(negedge clk);
      chk("t4_valid_at_t", 32'(b1.if_valid_o), 32'd1);
      chk("t4_req_at_t",   32'(b1.mem_req_o),  32'd0);
      tick();
      redirect = 1'b0;
      @(negedge clk);
      chk("t4_valid_next", 32'(b1.if_valid_o), 32'd0);
      chk("t4_req_next",   32'(b1.mem_req_o),  32'd1);
      chk("t4_addr_next",  b1.mem_addr_o,      32'h0000_0400);
      wait_valid("t4_wait", ok);
      if (ok) chk("t4_pc", b1.if_pc_o, 32'h0000_0400);
      repeat (3) tick();

      // 2: consumer stalled -> credit limit
      redirect = 1'b1; redirect_pc = 32'h0000_0200; b1.if_ready_i = 1'b0;
      tick();
      redirect = 1'b0;
      grants = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (b1.mem_req_o && b1.mem_gnt_i) grants++;
         tick();
      end
      chk("t2_grants", 32'(grants), 32'd4);
      @(negedge clk);
      chk("t2_req_blocked", 32'(b1.mem_req_o),  32'd0);
      chk("t2_head_valid",  32'(b1.if_valid_o), 32'd1);
      chk("t2_head_pc",     b1.if_pc_o,         32'h0000_0200);
      tick();
      b1.if_ready_i = 1'b1;
      repeat (8) tick();

      // 6: async reset with three in flight and one queued
      rsp_en = 1'b0; b1.if_ready_i = 1'b0;
      tick(); tick();
      #2 reset = 1'b1;
      #1;
      chk("t6_req",   32'(b1.mem_req_o),  32'd0);
      chk("t6_valid", 32'(b1.if_valid_o), 32'd0);
      chk("t6_pc",    b1.if_pc_o,         32'h0);
      chk("t6_pc4",   b1.if_pcPlusFour_o, 32'h0);
      chk("t6_inst",  b1.if_inst_o,       32'h0);
      rsp_en = 1'b1; b1.if_ready_i = 1'b1;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_restart_addr", b1.mem_addr_o, 32'h0);
      wait_valid("t6_wait", ok);
      if (ok) begin
         chk("t6_pc",   b1.if_pc_o,   32'h0);
         chk("t6_inst", b1.if_inst_o, inst_of(32'h0));
      end
      repeat (8) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
